// File: rtl/branch_resolver_pkg.sv
// Shared constants and encodings for the branch resolver and the benches
// that drive it.
package branch_resolver_pkg;

    localparam int WORD_SIZE = 16;

    // Two-bit branch history states of the downstream predictor.
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_state_e;

endpackage

// File: rtl/branch_resolver_sat_counter.sv
// Width-parameterised event counter that sticks at all-ones instead of
// wrapping, so statistics never roll back to small values.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] count_r;

    // Count requested events, holding once the maximum is reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (inc && (count_r != MAX)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/branch_resolver.sv
// IF/ID boundary branch resolver: latches the predictor's guess with each
// fetched PC, checks it against the real outcome in ID, redirects fetch in
// the same cycle on a mispredict and returns a registered one-cycle update
// to the predictor. Also keeps resolve/mispredict statistics.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int WORD  = WORD_SIZE,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [WORD-1:0]  if_pc,
    input  logic             if_pred_taken,
    input  logic [WORD-1:0]  if_pred_target,
    input  logic             stall,
    input  logic             id_is_branch,
    input  logic             id_is_jump,
    input  logic             id_cond_taken,
    input  logic [WORD-1:0]  id_target,
    output logic             id_valid,
    output logic [WORD-1:0]  id_pc,
    output logic             redirect,
    output logic [WORD-1:0]  redirect_pc,
    output logic             upd_is_predict,
    output logic             upd_flush,
    output logic             upd_btb_write,
    output logic [WORD-1:0]  upd_pc,
    output logic [WORD-1:0]  upd_target,
    output logic [CNT_W-1:0] resolve_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam logic [WORD-1:0] PC_STEP = {{(WORD-1){1'b0}}, 1'b1};

    // IF/ID pipeline register
    logic            id_valid_r;
    logic [WORD-1:0] id_pc_r;
    logic            pred_taken_r;
    logic [WORD-1:0] pred_target_r;

    // Predictor update register
    logic            upd_is_predict_r;
    logic            upd_flush_r;
    logic            upd_btb_write_r;
    logic [WORD-1:0] upd_pc_r;
    logic [WORD-1:0] upd_target_r;

    // Resolution terms
    logic            resolve_s;
    logic            ctrl_s;
    logic            actual_taken_s;
    logic            target_mismatch_s;
    logic            mispredict_s;
    logic            redirect_s;
    logic            btb_write_s;
    logic [WORD-1:0] fallthrough_s;
    logic [WORD-1:0] next_pc_s;

    // Compare the latched guess with the real outcome of the ID instruction
    always_comb begin
        resolve_s         = id_valid_r & ~stall;
        ctrl_s            = id_is_branch | id_is_jump;
        actual_taken_s    = id_is_jump | (id_is_branch & id_cond_taken);
        target_mismatch_s = (pred_target_r != id_target);
        fallthrough_s     = id_pc_r + PC_STEP;
        next_pc_s         = fallthrough_s;
        mispredict_s      = 1'b0;
        if (actual_taken_s) begin
            next_pc_s = id_target;
        end else begin
            next_pc_s = fallthrough_s;
        end
        if (ctrl_s) begin
            // Wrong direction, or right direction but wrong taken target
            mispredict_s = (pred_taken_r != actual_taken_s)
                         | (actual_taken_s & pred_taken_r & target_mismatch_s);
        end else begin
            // A taken guess on a non-control instruction is a BTB alias
            mispredict_s = pred_taken_r;
        end
        redirect_s  = resolve_s & mispredict_s;
        btb_write_s = resolve_s & ctrl_s & actual_taken_s
                    & (~pred_taken_r | target_mismatch_s);
    end

    // IF/ID register: a redirect kills the wrong-path fetch, stall holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid_r    <= 1'b0;
            id_pc_r       <= '0;
            pred_taken_r  <= 1'b0;
            pred_target_r <= '0;
        end else if (redirect_s) begin
            id_valid_r    <= 1'b0;
        end else if (stall) begin
            id_valid_r    <= id_valid_r;
        end else begin
            id_valid_r    <= if_valid;
            id_pc_r       <= if_pc;
            pred_taken_r  <= if_pred_taken;
            pred_target_r <= if_pred_target;
        end
    end

    // One-cycle predictor update; PC/target hold between control resolves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_is_predict_r <= 1'b0;
            upd_flush_r      <= 1'b0;
            upd_btb_write_r  <= 1'b0;
            upd_pc_r         <= '0;
            upd_target_r     <= '0;
        end else begin
            upd_is_predict_r <= resolve_s & ctrl_s;
            upd_flush_r      <= resolve_s & ctrl_s & mispredict_s;
            upd_btb_write_r  <= btb_write_s;
            if (resolve_s && ctrl_s) begin
                upd_pc_r     <= id_pc_r;
                upd_target_r <= id_target;
            end else begin
                upd_pc_r     <= upd_pc_r;
                upd_target_r <= upd_target_r;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_resolve_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (resolve_s & ctrl_s),
        .count (resolve_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_s),
        .count (mispredict_cnt)
    );

    assign id_valid       = id_valid_r;
    assign id_pc          = id_pc_r;
    assign redirect       = redirect_s;
    assign redirect_pc    = next_pc_s;
    assign upd_is_predict = upd_is_predict_r;
    assign upd_flush      = upd_flush_r;
    assign upd_btb_write  = upd_btb_write_r;
    assign upd_pc         = upd_pc_r;
    assign upd_target     = upd_target_r;

endmodule
